// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU control codes, ALUop and funct encodings,
// control-word bit positions and the ALU control decode.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLL = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Bit positions in the 6-bit ID control word.
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_REGDST   = 0;

  typedef struct packed {
    alu_ctl_e ctl;
    logic     valid;   // 0 for an unknown R-type funct; the write is suppressed
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input aluop_e aluop, input logic [5:0] funct);
    alu_dec_t res;
    res.ctl   = ALU_ADD;
    res.valid = 1'b1;
    case (aluop)
      ALUOP_ADD: res.ctl = ALU_ADD;
      ALUOP_SUB: res.ctl = ALU_SUB;
      ALUOP_ORI: res.ctl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: res.ctl = ALU_ADD;
          FUNCT_SUB: res.ctl = ALU_SUB;
          FUNCT_AND: res.ctl = ALU_AND;
          FUNCT_OR:  res.ctl = ALU_OR;
          FUNCT_SLT: res.ctl = ALU_SLT;
          FUNCT_SLL: res.ctl = ALU_SLL;
          default:   res.valid = 1'b0;
        endcase
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one ALU source: EX/MEM beats MEM/WB beats the
// registered value; register 0 is never forwarded.
import cpu_pkg::*;

module fwd_unit #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic [RW-1:0] exm_wreg,
  input  logic          exm_regwrite,
  input  logic [DW-1:0] exm_result,
  input  logic [RW-1:0] mwb_wreg,
  input  logic          mwb_regwrite,
  input  logic [DW-1:0] mwb_wdata,
  output logic [DW-1:0] data
);

  always_comb begin
    data = reg_data;
    if (exm_regwrite && exm_wreg != '0 && exm_wreg == idx)
      data = exm_result;
    else if (mwb_regwrite && mwb_wreg != '0 && mwb_wreg == idx)
      data = mwb_wdata;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, operand forwarding and
// load-use stall. Define ID_EX_FWD_EN to enable forwarding; otherwise every
// RAW dependency stalls until the producer has written back.
import cpu_pkg::*;

module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_ctrl,
  input  logic          flush,
  input  logic [RW-1:0] exm_wreg,
  input  logic          exm_regwrite,
  input  logic [DW-1:0] exm_result,
  input  logic [RW-1:0] mwb_wreg,
  input  logic          mwb_regwrite,
  input  logic [DW-1:0] mwb_wdata,
  output logic          stall,
  output logic [DW-1:0] alu_dataA,
  output logic [DW-1:0] alu_dataB,
  output logic [2:0]    alu_ctl,
  output logic [4:0]    alu_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_wreg,
  output logic [3:0]    ex_ctrl
);

  typedef struct packed {
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [4:0]    shamt;
    logic [2:0]    alu_ctl;
    logic [5:0]    ctrl;
  } idex_t;

  // Reset value and bubble are the same NOP.
  localparam idex_t IDEX_NOP = '{alu_ctl: ALU_ADD, default: '0};

  idex_t    idex_q, idex_d;
  alu_dec_t dec;
  logic     load_use, raw_hazard, stall_raw, bubble;

  assign load_use = idex_q.ctrl[CTRL_MEMREAD] && idex_q.rt != '0 &&
                    (idex_q.rt == id_rs || idex_q.rt == id_rt);
  assign stall_raw = load_use | raw_hazard;
  assign bubble    = flush | stall_raw;
  assign stall     = stall_raw & ~flush;

  always_comb begin
    dec    = alu_decode(aluop_e'(id_aluop), id_funct);
    idex_d = '{rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
               rs: id_rs, rt: id_rt, rd: id_rd, shamt: id_shamt,
               alu_ctl: dec.ctl, ctrl: id_ctrl};
    idex_d.ctrl[CTRL_REGWRITE] = id_ctrl[CTRL_REGWRITE] & dec.valid;
    if (bubble)
      idex_d = IDEX_NOP;
  end

  // NOTE: the asynchronous reset lives in the sensitivity list, and all state
  // updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idex_q <= IDEX_NOP;
    else
      idex_q <= idex_d;
  end

  logic [DW-1:0] fwd_a, fwd_b;

`ifdef ID_EX_FWD_EN
  fwd_unit #(.DW(DW), .RW(RW)) u_fwd_a (
    .idx(idex_q.rs), .reg_data(idex_q.rs_data),
    .exm_wreg(exm_wreg), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_wreg(mwb_wreg), .mwb_regwrite(mwb_regwrite), .mwb_wdata(mwb_wdata),
    .data(fwd_a)
  );

  fwd_unit #(.DW(DW), .RW(RW)) u_fwd_b (
    .idx(idex_q.rt), .reg_data(idex_q.rt_data),
    .exm_wreg(exm_wreg), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_wreg(mwb_wreg), .mwb_regwrite(mwb_regwrite), .mwb_wdata(mwb_wdata),
    .data(fwd_b)
  );

  assign raw_hazard = 1'b0;
`else
  logic rs_busy, rt_busy, unused_fwd;

  // Without forwarding, any pending writer of a source register holds ID.
  assign rs_busy = id_rs != '0 &&
                   ((idex_q.ctrl[CTRL_REGWRITE] && id_rs == ex_wreg) ||
                    (exm_regwrite && id_rs == exm_wreg) ||
                    (mwb_regwrite && id_rs == mwb_wreg));
  assign rt_busy = id_rt != '0 &&
                   ((idex_q.ctrl[CTRL_REGWRITE] && id_rt == ex_wreg) ||
                    (exm_regwrite && id_rt == exm_wreg) ||
                    (mwb_regwrite && id_rt == mwb_wreg));
  assign raw_hazard = rs_busy | rt_busy;

  assign fwd_a      = idex_q.rs_data;
  assign fwd_b      = idex_q.rt_data;
  assign unused_fwd = ^{exm_result, mwb_wdata, idex_q.rs};
`endif

  assign alu_dataA     = fwd_a;
  assign alu_dataB     = idex_q.ctrl[CTRL_ALUSRC] ? idex_q.imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_ctl       = idex_q.alu_ctl;
  assign alu_shamt     = idex_q.shamt;
  assign ex_wreg       = idex_q.ctrl[CTRL_REGDST] ? idex_q.rd : idex_q.rt;
  assign ex_ctrl       = idex_q.ctrl[5:2];

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode vector table plus directed
// sequences for reset, forwarding, load-use, flush and RAW stalls.
import cpu_pkg::*;

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct, id_ctrl;
  logic [1:0]  id_aluop;
  logic        flush;
  logic [4:0]  exm_wreg, mwb_wreg;
  logic        exm_regwrite, mwb_regwrite;
  logic [31:0] exm_result, mwb_wdata;
  logic        stall;
  logic [31:0] alu_dataA, alu_dataB, ex_store_data;
  logic [2:0]  alu_ctl;
  logic [4:0]  alu_shamt, ex_wreg;
  logic [3:0]  ex_ctrl;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_aluop(id_aluop), .id_ctrl(id_ctrl),
    .flush(flush),
    .exm_wreg(exm_wreg), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_wreg(mwb_wreg), .mwb_regwrite(mwb_regwrite), .mwb_wdata(mwb_wdata),
    .stall(stall), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
    .alu_ctl(alu_ctl), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
    .ex_wreg(ex_wreg), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic [5:0]  ctrl;
    logic [2:0]  e_ctl;
    logic [31:0] e_a, e_b, e_st;
    logic [4:0]  e_wreg;
    logic [3:0]  e_ctrl;
    logic [4:0]  e_shamt;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [1:0] aluop, input logic [5:0] ctrl);
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_shamt = shamt; id_funct = funct; id_aluop = aluop; id_ctrl = ctrl;
  endtask

  task automatic id_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 6'h00, 2'b00, 6'b000000);
  endtask

  task automatic set_fwd(input logic [4:0] ew, input logic erw, input logic [31:0] er,
                         input logic [4:0] mw, input logic mrw, input logic [31:0] md);
    exm_wreg = ew; exm_regwrite = erw; exm_result = er;
    mwb_wreg = mw; mwb_regwrite = mrw; mwb_wdata = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rs rt rd rsd rtd imm shamt funct aluop ctrl | ctl a b st wreg ectrl shamt
    vecs[0]  = '{1, 2, 3, 5, 7, 32'h100, 0, FUNCT_ADD, 2'b10, 6'b100001, 3'b010, 5, 7, 7, 3, 4'b1000, 0};
    vecs[1]  = '{1, 2, 3, 5, 7, 32'h100, 0, FUNCT_SUB, 2'b10, 6'b100001, 3'b110, 5, 7, 7, 3, 4'b1000, 0};
    vecs[2]  = '{1, 2, 3, 5, 7, 32'h100, 0, FUNCT_AND, 2'b10, 6'b100001, 3'b000, 5, 7, 7, 3, 4'b1000, 0};
    vecs[3]  = '{1, 2, 3, 5, 7, 32'h100, 0, FUNCT_OR,  2'b10, 6'b100001, 3'b001, 5, 7, 7, 3, 4'b1000, 0};
    vecs[4]  = '{1, 2, 3, 5, 7, 32'h100, 0, FUNCT_SLT, 2'b10, 6'b100001, 3'b111, 5, 7, 7, 3, 4'b1000, 0};
    vecs[5]  = '{1, 2, 3, 5, 1, 32'h100, 4, FUNCT_SLL, 2'b10, 6'b100001, 3'b011, 5, 1, 1, 3, 4'b1000, 4};
    vecs[6]  = '{1, 2, 3, 5, 7, 32'h100, 0, 6'h3F,     2'b10, 6'b100001, 3'b010, 5, 7, 7, 3, 4'b0000, 0};
    vecs[7]  = '{1, 6, 3, 5, 7, 32'hFFFF_FFF0, 0, 6'h00, 2'b00, 6'b100010, 3'b010, 5, 32'hFFFF_FFF0, 7, 6, 4'b1000, 0};
    vecs[8]  = '{1, 2, 3, 5, 7, 32'h100, 0, 6'h00, 2'b01, 6'b000000, 3'b110, 5, 7, 7, 2, 4'b0000, 0};
    vecs[9]  = '{1, 4, 3, 5, 7, 32'hFF, 7, 6'h00, 2'b11, 6'b100010, 3'b001, 5, 32'hFF, 7, 4, 4'b1000, 7};
    vecs[10] = '{1, 8, 3, 5, 7, 32'h4, 0, 6'h00, 2'b00, 6'b110110, 3'b010, 5, 4, 7, 8, 4'b1101, 0};
    vecs[11] = '{1, 9, 3, 5, 32'hCAFE, 32'h8, 0, 6'h00, 2'b00, 6'b001010, 3'b010, 5, 8, 32'hCAFE, 9, 4'b0010, 0};

    rst_n = 1'b0;
    flush = 1'b0;
    id_nop();
    set_fwd(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_alu_ctl", alu_ctl, 3'b010);
    check("rst_ex_ctrl", ex_ctrl, 4'b0000);
    check("rst_ex_wreg", ex_wreg, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // Decode table: capture a vector, drop ID to NOP, check, then flush EX with a NOP.
    foreach (vecs[i]) begin
      set_id(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rsd, vecs[i].rtd, vecs[i].imm,
             vecs[i].shamt, vecs[i].funct, vecs[i].aluop, vecs[i].ctrl);
      tick();
      id_nop();
      #1;
      check($sformatf("v%0d_alu_ctl", i), alu_ctl, vecs[i].e_ctl);
      check($sformatf("v%0d_dataA", i), alu_dataA, vecs[i].e_a);
      check($sformatf("v%0d_dataB", i), alu_dataB, vecs[i].e_b);
      check($sformatf("v%0d_store", i), ex_store_data, vecs[i].e_st);
      check($sformatf("v%0d_wreg", i), ex_wreg, vecs[i].e_wreg);
      check($sformatf("v%0d_ex_ctrl", i), ex_ctrl, vecs[i].e_ctrl);
      check($sformatf("v%0d_shamt", i), alu_shamt, vecs[i].e_shamt);
      tick();
    end

    // Asynchronous reset mid-instruction.
    set_id(1, 2, 3, 32'h55, 32'h66, 0, 3, FUNCT_SUB, 2'b10, 6'b100001);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_alu_ctl", alu_ctl, 3'b010);
    check("async_rst_dataA", alu_dataA, 0);
    check("async_rst_ex_ctrl", ex_ctrl, 0);
    check("async_rst_wreg", ex_wreg, 0);
    check("async_rst_shamt", alu_shamt, 0);
    check("async_rst_stall", stall, 0);
    id_nop();
    #1;
    rst_n = 1'b1;
    tick();

    // add $3,$1,$2 then sub $4,$3,$1.
    set_id(1, 2, 3, 32'h1, 32'h2, 0, 0, FUNCT_ADD, 2'b10, 6'b100001);
    tick();
    set_id(3, 1, 4, 32'hDEAD, 32'h1, 0, 0, FUNCT_SUB, 2'b10, 6'b100001);
    #1;
`ifdef ID_EX_FWD_EN
    check("dep_no_stall", stall, 0);
    tick();
    id_nop();
    set_fwd(3, 1, 32'h10, 0, 0, 0);
    #1;
`else
    check("raw_stall_ex", stall, 1);
    tick();
    set_fwd(3, 1, 32'h10, 0, 0, 0);
    #1;
    check("raw_bubble_ex_ctrl", ex_ctrl, 0);
    check("raw_stall_exm", stall, 1);
    tick();
    set_fwd(0, 0, 0, 3, 1, 32'h10);
    #1;
    check("raw_stall_mwb", stall, 1);
    tick();
    set_fwd(0, 0, 0, 0, 0, 0);
    id_rs_data = 32'h10;
    #1;
    check("raw_stall_released", stall, 0);
    tick();
    id_nop();
    #1;
`endif
    check("dep_sub_dataA", alu_dataA, 32'h10);
    check("dep_sub_alu_ctl", alu_ctl, 3'b110);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();

    // Forwarding priority on $5, with ALUSrc selecting the immediate for B.
    set_id(5, 5, 6, 32'h99, 32'h55, 32'h1234, 0, 6'h00, 2'b00, 6'b100011);
    tick();
    id_nop();
    set_fwd(5, 1, 32'h11, 5, 1, 32'h22);
    #1;
    check("prio_both_dataA", alu_dataA, FWD ? 32'h11 : 32'h99);
    check("prio_alusrc_dataB", alu_dataB, 32'h1234);
    check("prio_both_store", ex_store_data, FWD ? 32'h11 : 32'h55);
    set_fwd(5, 0, 32'h11, 5, 1, 32'h22);
    #1;
    check("prio_mwb_dataA", alu_dataA, FWD ? 32'h22 : 32'h99);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    set_id(0, 0, 6, 32'h77, 32'h66, 0, 0, FUNCT_ADD, 2'b10, 6'b100001);
    tick();
    id_nop();
    set_fwd(0, 1, 32'h11, 0, 1, 32'h22);
    #1;
    check("zero_reg_dataA", alu_dataA, 32'h77);
    check("zero_reg_store", ex_store_data, 32'h66);
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();

    // Load-use: lw $2 in EX, next instruction reads $2 through rt.
    set_id(1, 2, 0, 32'h1, 32'h0, 32'h4, 0, 6'h00, 2'b00, 6'b110110);
    tick();
    set_id(9, 2, 8, 32'h3, 32'h4, 0, 0, FUNCT_ADD, 2'b10, 6'b100001);
    #1;
    check("load_use_stall", stall, 1);
    tick();
    set_fwd(2, 1, 32'hAB, 0, 0, 0);
    #1;
    check("load_use_bubble_ctrl", ex_ctrl, 0);
    check("load_use_bubble_wreg", ex_wreg, 0);
    check("load_use_stall_after", stall, FWD ? 1'b0 : 1'b1);
    id_nop();
    set_fwd(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Flush coinciding with a load-use condition.
    set_id(1, 2, 0, 32'h1, 32'h0, 32'h4, 0, 6'h00, 2'b00, 6'b110110);
    tick();
    set_id(2, 7, 8, 32'h3, 32'h4, 0, 0, FUNCT_ADD, 2'b10, 6'b100001);
    flush = 1'b1;
    #1;
    check("flush_stall", stall, 0);
    tick();
    flush = 1'b0;
    id_nop();
    #1;
    check("flush_bubble_ctrl", ex_ctrl, 0);
    check("flush_bubble_alu_ctl", alu_ctl, 3'b010);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipeline CPU. It sits directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID each cycle.
- Generates the 3-bit ALU ctl and shamt, and drives forwarded dataA/dataB into the ALU.
- Detects load-use hazards: it stalls IF/ID and inserts a bubble.

Parameters:
DW, 32, datapath width
RW, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_rs_data  input  DW  register-file read A
id_rt_data  input  DW  register-file read B
id_imm  input  DW  sign-extended immediate
id_rs, id_rt, id_rd  input  RW each  register indices
id_shamt  input  5  shift amount field
id_funct  input  6  R-type funct
id_aluop  input  2  00 add, 01 sub, 10 R-type, 11 or-immediate
id_ctrl  input  6  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst}
flush  input  1  branch taken; squash instruction entering EX
exm_wreg  input  RW  EX/MEM destination
exm_regwrite  input  1  EX/MEM write enable
exm_result  input  DW  EX/MEM ALU result
mwb_wreg  input  RW  MEM/WB destination
mwb_regwrite  input  1  MEM/WB write enable
mwb_wdata  input  DW  MEM/WB writeback data
stall  output  1  hold PC and IF/ID this cycle
alu_dataA  output  DW  ALU operand A
alu_dataB  output  DW  ALU operand B (after ALUSrc mux)
alu_ctl  output  3  ALU control
alu_shamt  output  5  ALU shift amount
ex_store_data  output  DW  forwarded rt for stores
ex_wreg  output  RW  selected destination (RegDst ? rd : rt)
ex_ctrl  output  4  {RegWrite, MemRead, MemWrite, MemtoReg}

Behaviour:
- Reset (async, rst_n=0):
  - All ID/EX registers clear to 0, which is a NOP.
  - alu_ctl=3'b010, ex_ctrl=0, ex_wreg=0, stall=0.
  - Reset asserted mid-stream discards the in-flight instruction.
- Latency: one clock from ID inputs to EX outputs. Forwarding muxes and the ALU-ctl decode are combinational from registered state plus exm_*/mwb_* inputs.
- ALU ctl decode, registered at capture:
  - aluop 00 → 010
  - aluop 01 → 110
  - aluop 11 → 001
  - aluop 10, by funct:
    - 0x20 → 010
    - 0x22 → 110
    - 0x24 → 000
    - 0x25 → 001
    - 0x2A → 111
    - 0x00 → 011 (sll)
    - other → 010 with RegWrite forced 0
- Load-use stall:
  - Condition: registered MemRead=1 and registered rt≠0 and (registered rt==id_rs or registered rt==id_rt).
  - Then stall=1 for exactly one cycle, and the next capture loads a bubble (all control 0) while ID holds.
- Flush: the next capture loads a bubble and stall is forced to 0. Flush takes priority over stall when both apply in the same cycle.
- Forwarding, per operand A (rs) and B (rt):
  - Priority 1: EX/MEM when exm_regwrite and exm_wreg≠0 and exm_wreg==index.
  - Priority 2: MEM/WB under the same rule.
  - Otherwise the registered data.
  - Register 0 is never forwarded.
  - ALUSrc selects the registered imm for alu_dataB after forwarding. ex_store_data always takes the forwarded rt.
- Writeback bypass is not handled here; the register file is write-before-read.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined: no forwarding muxes; operands come straight from the registers. stall additionally asserts whenever id_rs/id_rt (≠0) matches the destination of a RegWrite instruction in EX (registered), EX/MEM, or MEM/WB. Each such stall inserts a bubble.

Decomposition:
- Shared package cpu_pkg:
  - ALU ctl constants: ADD=010, SUB=110, AND=000, OR=001, SLT=111, SLL=011.
  - aluop encodings.
  - funct codes.
  - ctrl bit positions.
- One sub-module, fwd_unit: combinational priority compare for one operand, instantiated twice.

Test Plan:
- Reset: rst_n low mid-instruction → all outputs zero, alu_ctl=010, stall=0, immediately and asynchronously.
- add $3,$1,$2 followed by sub $4,$3,$1, with exm_result=0x0000_0010 → alu_dataA=0x10, alu_ctl=110.
- Double hazard: EX/MEM and MEM/WB both target $5 (0x11, 0x22) → alu_dataA=0x11. Same case with target $0 → registered value used.
- lw $2 in EX, next instruction reads $2 → stall=1 for one cycle, bubble: ex_ctrl=0 next cycle.
- flush=1 in the same cycle as a load-use condition → stall=0, bubble captured.
- funct=0x00 with shamt=4, rt data 0x1 → alu_ctl=011, alu_shamt=4, alu_dataB=0x1. Without ID_EX_FWD_EN, the back-to-back dependency stalls 3 cycles.
